// File: rtl/jts16_rom_pkg.sv
// Shared types and helpers for the S16 video ROM-slot responder.
package jts16_rom_pkg;

  typedef enum logic [1:0] {StIdle, StAck, StData} rom_state_e;

  localparam int unsigned AW_DEF     = 20;
  localparam int unsigned SDW_DEF    = 22;
  localparam int unsigned MAX_SLOTS  = 8;
  localparam int unsigned BASE_VEC_W = MAX_SLOTS * 32;

  // Extracts the sdw-bit base address of slot idx from a zero-extended packed vector.
  function automatic logic [31:0] slot_base(input logic [BASE_VEC_W-1:0] bases,
                                            input int unsigned           idx,
                                            input int unsigned           sdw);
    logic [BASE_VEC_W-1:0] sh;
    sh = bases >> (idx * sdw);
    return sh[31:0] & ((32'd1 << sdw) - 32'd1);
  endfunction

endpackage

// File: rtl/jts16_rr_arb.sv
// Round-robin priority encoder: first set request after ptr, wrapping modulo SLOTS.
module jts16_rr_arb #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned IW    = $clog2(SLOTS)
) (
  input  logic [SLOTS-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    winner,
  output logic             any
);

  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    // k = SLOTS wraps back onto ptr itself, so the last winner has lowest priority
    for (int unsigned k = 1; k <= SLOTS; k++) begin
      idx = IW'((32'(ptr) + k) % SLOTS);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/jts16_rom_rsp.sv
// ROM-slot responder: one-entry cache per slot, round-robin misses onto one SDRAM read port.
module jts16_rom_rsp
  import jts16_rom_pkg::*;
#(
  parameter int unsigned          SLOTS     = 4,
  parameter int unsigned          AW        = AW_DEF,
  parameter int unsigned          SDW       = SDW_DEF,
  parameter logic [SLOTS*SDW-1:0] SLOT_BASE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*32-1:0] slot_data,
  output logic                sdram_req,
  output logic [SDW-1:0]      sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [31:0]         sdram_din
);

  localparam int unsigned IW   = $clog2(SLOTS);
  localparam int unsigned SUMW = (SDW > AW + 1) ? SDW : AW + 1;
  localparam logic [BASE_VEC_W-1:0] BASE_VEC = BASE_VEC_W'(SLOT_BASE);

  logic [AW-1:0]  addr_a  [SLOTS];
  logic [SDW-1:0] base_a  [SLOTS];
  logic [AW-1:0]  tag_q   [SLOTS];
  logic [31:0]    data_q  [SLOTS];
  logic [SLOTS-1:0] valid_q, hit, miss, ok_d, ok_q;

  rom_state_e     state_q, state_d;
  logic [IW-1:0]  win_q, win_d, ptr_q, ptr_d, arb_win;
  logic           arb_any;
  logic [AW-1:0]  lat_addr_q, lat_addr_d;
  logic           req_q, req_d;
  logic [SDW-1:0] sdaddr_q, sdaddr_d;
  logic [SUMW-1:0] sum;
  logic           fill;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    assign addr_a[g]             = slot_addr[g*AW +: AW];
    assign base_a[g]             = SDW'(slot_base(BASE_VEC, g, SDW));
    assign hit[g]                = valid_q[g] & (tag_q[g] == addr_a[g]);
    assign miss[g]               = slot_cs[g] & ~hit[g];
    assign slot_data[g*32 +: 32] = data_q[g];
  end

  jts16_rr_arb #(
    .SLOTS (SLOTS),
    .IW    (IW)
  ) u_arb (
    .req    (miss),
    .ptr    (ptr_q),
    .winner (arb_win),
    .any    (arb_any)
  );

  // Slot address is in 32-bit words, SDRAM in 16-bit words.
  assign sum = SUMW'(base_a[arb_win]) + SUMW'({addr_a[arb_win], 1'b0});

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    ptr_d      = ptr_q;
    lat_addr_d = lat_addr_q;
    req_d      = req_q;
    sdaddr_d   = sdaddr_q;
    fill       = 1'b0;
    ok_d       = '0;

    case (state_q)
      StIdle: begin
        if (arb_any) begin
          win_d      = arb_win;
          lat_addr_d = addr_a[arb_win];
          sdaddr_d   = sum[SDW-1:0];
          req_d      = 1'b1;
          state_d    = StAck;
        end
      end
      StAck: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          // Controller may return data in the same cycle it accepts the request
          if (sdram_rdy) begin
            fill    = 1'b1;
            ptr_d   = win_q;
            state_d = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (sdram_rdy) begin
          fill    = 1'b1;
          ptr_d   = win_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    for (int unsigned i = 0; i < SLOTS; i++) begin
      ok_d[i] = slot_cs[i] & hit[i] & ~(fill & (win_q == IW'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      win_q      <= '0;
      ptr_q      <= '0;
      lat_addr_q <= '0;
      req_q      <= 1'b0;
      sdaddr_q   <= '0;
      ok_q       <= '0;
      valid_q    <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      ptr_q      <= ptr_d;
      lat_addr_q <= lat_addr_d;
      req_q      <= req_d;
      sdaddr_q   <= sdaddr_d;
      ok_q       <= ok_d;
      // The latched tag is stored even if the slot has since moved on; it then simply misses.
      if (fill) begin
        tag_q[win_q]   <= lat_addr_q;
        data_q[win_q]  <= sdram_din;
        valid_q[win_q] <= 1'b1;
      end
    end
  end

  assign slot_ok    = ok_q;
  assign sdram_req  = req_q;
  assign sdram_addr = sdaddr_q;

endmodule

// File: tb/tb_jts16_rom_rsp.sv
// Self-checking bench for jts16_rom_rsp with a scripted SDRAM responder and request scoreboard.
module tb_jts16_rom_rsp;

  localparam int unsigned SLOTS = 4;
  localparam int unsigned AW    = 20;
  localparam int unsigned SDW   = 22;
  localparam logic [SLOTS*SDW-1:0] BASES =
    {22'h040000, 22'h300000, 22'h200000, 22'h100000};

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [SLOTS-1:0]    slot_cs = '0;
  logic [SLOTS*AW-1:0] slot_addr = '0;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*32-1:0] slot_data;
  logic                sdram_req;
  logic [SDW-1:0]      sdram_addr;
  logic                sdram_ack = 1'b0;
  logic                rdy_m = 1'b0;
  logic                force_rdy = 1'b0;
  logic                sdram_rdy;
  logic [31:0]         sdram_din = '0;

  assign sdram_rdy = rdy_m | force_rdy;

  jts16_rom_rsp #(
    .SLOTS     (SLOTS),
    .AW        (AW),
    .SDW       (SDW),
    .SLOT_BASE (BASES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .slot_cs    (slot_cs),
    .slot_addr  (slot_addr),
    .slot_ok    (slot_ok),
    .slot_data  (slot_data),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_rdy  (sdram_rdy),
    .sdram_din  (sdram_din)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    if (a == 22'h100024) return 32'hDEADBEEF;
    return 32'hC0DE0000 ^ {10'd0, a};
  endfunction

  function automatic logic [31:0] sdata(input int s);
    return slot_data[s*32 +: 32];
  endfunction

  // SDRAM responder: ack at t == ack_dly, rdy at t == rdy_dly after a request is first seen.
  logic [21:0] exp_q[$];
  logic [21:0] cur_addr = '0;
  int  ack_dly = 2, rdy_dly = 5, t = 0;
  int  req_cnt = 0, rdy_cnt = 0, last_rdy_cyc = 0;
  bit  active = 1'b0, mdl_clr = 1'b0;

  always @(negedge clk) begin
    sdram_ack = 1'b0;
    rdy_m     = 1'b0;
    if (mdl_clr) begin
      active = 1'b0;
    end else if (active) begin
      t++;
    end else if (sdram_req) begin
      active   = 1'b1;
      t        = 0;
      req_cnt++;
      cur_addr = sdram_addr;
      check("req_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sdram_addr", 32'(sdram_addr), 32'(exp_q.pop_front()));
    end
    if (active && !mdl_clr) begin
      if (t == ack_dly) sdram_ack = 1'b1;
      if (t == rdy_dly) begin
        rdy_m        = 1'b1;
        sdram_din    = mem_word(cur_addr);
        last_rdy_cyc = cyc;
        rdy_cnt++;
        active       = 1'b0;
      end
    end
  end

  task automatic set_addr(input int s, input logic [AW-1:0] a);
    slot_addr[s*AW +: AW] = a;
  endtask

  task automatic wait_ok(input logic [SLOTS-1:0] mask, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((slot_ok & mask) == mask) begin
        at = cyc;
        break;
      end
    end
    check("ok_timeout", 32'(at != -1), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int at, rc0, c0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ok",    32'(slot_ok), 32'd0);
    check("rst_req",   32'(sdram_req), 32'd0);
    check("rst_saddr", 32'(sdram_addr), 32'd0);
    check("rst_data0", sdata(0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single miss on slot 0
    exp_q.push_back(22'h100024);
    slot_cs[0] = 1'b1;
    set_addr(0, 20'h00012);
    wait_ok(4'b0001, at);
    check("miss_lat",   32'(at - last_rdy_cyc), 32'd2);
    check("miss_data",  sdata(0), 32'hDEADBEEF);
    check("miss_nreq",  32'(req_cnt), 32'd1);

    // Hit: hold, then toggle cs
    repeat (50) @(negedge clk);
    check("hit_ok",   32'(slot_ok[0]), 32'd1);
    slot_cs[0] = 1'b0;
    @(negedge clk);
    check("cs_low_ok", 32'(slot_ok[0]), 32'd0);
    slot_cs[0] = 1'b1;
    @(negedge clk);
    check("cs_high_ok", 32'(slot_ok[0]), 32'd1);
    check("hit_data",   sdata(0), 32'hDEADBEEF);
    check("hit_nreq",   32'(req_cnt), 32'd1);

    // Round robin: all four miss, ptr = 0 -> order 1, 2, 3, 0
    ack_dly = 1;
    rdy_dly = 3;
    exp_q.push_back(22'h200200);
    exp_q.push_back(22'h300080);
    exp_q.push_back(22'h0400EE);
    exp_q.push_back(22'h100040);
    slot_cs = 4'hF;
    set_addr(0, 20'h00020);
    set_addr(1, 20'h00100);
    set_addr(2, 20'h00040);
    set_addr(3, 20'h00077);
    wait_ok(4'hF, at);
    repeat (4) @(negedge clk);
    check("rr_nreq",  32'(req_cnt), 32'd5);
    check("rr_qempty", 32'(exp_q.size()), 32'd0);
    check("rr_data0", sdata(0), mem_word(22'h100040));
    check("rr_data1", sdata(1), mem_word(22'h200200));
    check("rr_data2", sdata(2), mem_word(22'h300080));
    check("rr_data3", sdata(3), mem_word(22'h0400EE));

    // Address change on slot 2 while in DATA
    rdy_dly = 4;
    rc0 = rdy_cnt;
    exp_q.push_back(22'h30000A);
    slot_cs = 4'b0100;
    set_addr(2, 20'h00005);
    repeat (3) @(negedge clk);
    check("chg_req_low", 32'(sdram_req), 32'd0);
    exp_q.push_back(22'h30000C);
    set_addr(2, 20'h00006);
    wait_ok(4'b0100, at);
    check("chg_nrdy", 32'(rdy_cnt - rc0), 32'd2);
    check("chg_lat",  32'(at - last_rdy_cyc), 32'd2);
    check("chg_data", sdata(2), mem_word(22'h30000C));

    // Reset during ACK, then a stray rdy
    ack_dly = 50;
    rdy_dly = 60;
    rc0 = rdy_cnt;
    exp_q.push_back(22'h040200);
    slot_cs = 4'b1000;
    set_addr(3, 20'h00100);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    mdl_clr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_req",   32'(sdram_req), 32'd0);
    check("rst_mid_ok",    32'(slot_ok), 32'd0);
    check("rst_mid_data3", sdata(3), 32'd0);
    ack_dly   = 1;
    rdy_dly   = 2;
    force_rdy = 1'b1;
    exp_q.push_back(22'h040200);
    @(negedge clk);
    force_rdy = 1'b0;
    mdl_clr   = 1'b0;
    check("stray_rdy_ok",   32'(slot_ok), 32'd0);
    check("stray_rdy_data", sdata(3), 32'd0);
    wait_ok(4'b1000, at);
    check("refetch_nrdy", 32'(rdy_cnt - rc0), 32'd1);
    check("refetch_lat",  32'(at - last_rdy_cyc), 32'd2);
    check("refetch_data", sdata(3), mem_word(22'h040200));

    // ack and rdy together in the first ACK cycle
    ack_dly = 0;
    rdy_dly = 0;
    exp_q.push_back(22'h200666);
    slot_cs = 4'b0010;
    set_addr(1, 20'h00333);
    c0 = cyc;
    @(negedge clk);
    @(negedge clk);
    check("same_req_low", 32'(sdram_req), 32'd0);
    check("same_ok_low",  32'(slot_ok[1]), 32'd0);
    wait_ok(4'b0010, at);
    check("same_lat",  32'(at - c0), 32'd3);
    check("same_data", sdata(1), mem_word(22'h200666));

    repeat (3) @(negedge clk);
    check("total_nreq", 32'(req_cnt), 32'd10);
    check("final_qempty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
